// File: rtl/song_sequencer.sv
// Melody player: walks a per-song note table in an external synchronous ROM
// and drives key/key_on into the tone generator, with tempo, rests, looping and pause/stop.
module song_sequencer #(
  parameter int KEY_W     = 5,
  parameter int SEL_W     = 2,
  parameter int ADDR_W    = 5,
  parameter int BEAT_W    = 4,
  parameter int CNT_W     = 26,
  parameter int GAP_SHIFT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic                      i_stop,
  input  logic                      i_pause,
  input  logic                      i_loop,
  input  logic [SEL_W-1:0]          i_song_sel,
  input  logic [CNT_W-1:0]          i_unit_cycles,
  output logic [SEL_W+ADDR_W-1:0]   o_rom_addr,
  input  logic [2+BEAT_W+KEY_W-1:0] i_rom_data,
  output logic [KEY_W-1:0]          o_key,
  output logic                      o_key_on,
  output logic                      o_busy,
  output logic [ADDR_W-1:0]         o_note_idx,
  output logic                      o_done
);

  localparam int LEN_W = BEAT_W + CNT_W;
  localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] IDX_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] IDX_LAST = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_LOAD  = 2'd2,
    S_PLAY  = 2'd3
  } state_t;

  state_t             r_state;
  logic [SEL_W-1:0]   r_song;
  logic [ADDR_W-1:0]  r_note_idx;
  logic [KEY_W-1:0]   r_key;
  logic               r_key_on;
  logic               r_busy;
  logic               r_done;
  logic [LEN_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_gap;

  logic               w_end;
  logic               w_rest;
  logic [BEAT_W-1:0]  w_beats;
  logic [KEY_W-1:0]   w_key;
  logic [BEAT_W-1:0]  w_beats_eff;
  logic [CNT_W-1:0]   w_unit;
  logic [CNT_W-1:0]   w_gap;
  logic [LEN_W-1:0]   w_len;
  logic               w_last;

  assign w_end   = i_rom_data[KEY_W+BEAT_W+1];
  assign w_rest  = i_rom_data[KEY_W+BEAT_W];
  assign w_beats = i_rom_data[KEY_W+BEAT_W-1:KEY_W];
  assign w_key   = i_rom_data[KEY_W-1:0];

  // Zero beats or a zero tempo both behave as one unit; the product cannot overflow LEN_W.
  assign w_beats_eff = (w_beats == {BEAT_W{1'b0}}) ? {{(BEAT_W-1){1'b0}}, 1'b1} : w_beats;
  assign w_unit      = (i_unit_cycles == {CNT_W{1'b0}}) ? {{(CNT_W-1){1'b0}}, 1'b1} : i_unit_cycles;
  assign w_gap       = w_unit >> GAP_SHIFT;
  assign w_len       = {{CNT_W{1'b0}}, w_beats_eff} * {{BEAT_W{1'b0}}, w_unit};
  assign w_last      = (r_note_idx == IDX_LAST);

  assign o_rom_addr = {r_song, r_note_idx};
  assign o_key      = r_key;
  assign o_key_on   = r_key_on & ~i_pause;
  assign o_busy     = r_busy;
  assign o_note_idx = r_note_idx;
  assign o_done     = r_done;

  // Playback FSM with registered outputs; stop outranks pause, pause freezes everything else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_song     <= {SEL_W{1'b0}};
      r_note_idx <= IDX_ZERO;
      r_key      <= {KEY_W{1'b0}};
      r_key_on   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cnt      <= LEN_ZERO;
      r_gap      <= {CNT_W{1'b0}};
    end else begin
      r_done <= 1'b0;
      if (i_stop) begin
        r_state  <= S_IDLE;
        r_key_on <= 1'b0;
        r_busy   <= 1'b0;
      end else if (!i_pause) begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_song     <= i_song_sel;
              r_note_idx <= IDX_ZERO;
              r_busy     <= 1'b1;
              r_state    <= S_FETCH;
            end
          end
          S_FETCH: r_state <= S_LOAD;
          S_LOAD: begin
            if (w_end) begin
              r_done <= 1'b1;
              if (i_loop) begin
                r_note_idx <= IDX_ZERO;
                r_state    <= S_FETCH;
              end else begin
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end
            end else begin
              r_key    <= w_key;
              r_key_on <= ~w_rest;
              r_cnt    <= w_len - LEN_ONE;
              r_gap    <= w_gap;
              r_state  <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (r_cnt == {{BEAT_W{1'b0}}, r_gap}) begin
              r_key_on <= 1'b0;
            end
            if (r_cnt == LEN_ZERO) begin
              r_key_on <= 1'b0;
              // Running off the last table slot ends the song like a marker would.
              if (w_last) begin
                r_done <= 1'b1;
                if (i_loop) begin
                  r_note_idx <= IDX_ZERO;
                  r_state    <= S_FETCH;
                end else begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
                end
              end else begin
                r_note_idx <= r_note_idx + IDX_ONE;
                r_state    <= S_FETCH;
              end
            end else begin
              r_cnt <= r_cnt - LEN_ONE;
            end
          end
          default: begin
            r_state  <= S_IDLE;
            r_key_on <= 1'b0;
            r_busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer: a per-cycle trace model built from the
// note table, plus directed scenarios with hand-computed timing.
module tb_song_sequencer;

  logic        clk           = 1'b0;
  logic        rst           = 1'b1;
  logic        i_start       = 1'b0;
  logic        i_stop        = 1'b0;
  logic        i_pause       = 1'b0;
  logic        i_loop        = 1'b0;
  logic [1:0]  i_song_sel    = 2'd0;
  logic [25:0] i_unit_cycles = 26'd8;
  logic [6:0]  o_rom_addr;
  logic [10:0] rom_data      = 11'd0;
  logic [4:0]  o_key;
  logic        o_key_on;
  logic        o_busy;
  logic [4:0]  o_note_idx;
  logic        o_done;

  int n_checks = 0;
  int n_fail   = 0;

  song_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_stop       (i_stop),
    .i_pause      (i_pause),
    .i_loop       (i_loop),
    .i_song_sel   (i_song_sel),
    .i_unit_cycles(i_unit_cycles),
    .o_rom_addr   (o_rom_addr),
    .i_rom_data   (rom_data),
    .o_key        (o_key),
    .o_key_on     (o_key_on),
    .o_busy       (o_busy),
    .o_note_idx   (o_note_idx),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  // Note table words: {end, rest, beats[3:0], key[4:0]}
  logic [10:0] rom [0:127];
  always @(posedge clk) rom_data <= rom[o_rom_addr];

  initial begin
    for (int a = 0; a < 128; a++) rom[a] = 11'd0;
    rom[0]  = {1'b0, 1'b0, 4'd2, 5'd3};
    rom[1]  = {1'b1, 1'b0, 4'd0, 5'd0};
    rom[32] = {1'b0, 1'b0, 4'd1, 5'd5};
    rom[33] = {1'b0, 1'b1, 4'd1, 5'd9};
    rom[34] = {1'b0, 1'b0, 4'd3, 5'd7};
    rom[35] = {1'b1, 1'b0, 4'd0, 5'd0};
    rom[64] = {1'b0, 1'b0, 4'd1, 5'd2};
    rom[65] = {1'b0, 1'b0, 4'd0, 5'd4};
    rom[66] = {1'b1, 1'b0, 4'd0, 5'd0};
    for (int n = 0; n < 32; n++) begin
      logic [4:0] kk;
      kk = 5'(n + 1);
      rom[96 + n] = {1'b0, 1'b0, 4'd1, kk};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- trace model ----------------
  typedef struct packed {
    logic [4:0] key;
    logic       on;
    logic       busy;
    logic [4:0] idx;
    logic [1:0] song;
    logic       done;
  } exp_t;

  exp_t q[$];
  exp_t cur = '0;

  // Expand a whole song into the per-cycle outputs it must produce.
  task automatic build(input logic [1:0] song, input logic [4:0] key0,
                       input logic [25:0] unit, input bit lp);
    int u, gap, idx, iters, len, beats;
    logic [4:0]  k;
    logic [10:0] w;
    bit pend, ended;
    exp_t e;
    u = (unit == 26'd0) ? 1 : int'(unit);
    gap = u / 4;
    idx = 0; iters = 0; k = key0; pend = 0;
    while (1'b1) begin
      ended = 0;
      e = '{key: k, on: 1'b0, busy: 1'b1, idx: 5'(idx), song: song, done: pend};
      q.push_back(e);
      e.done = 1'b0;
      q.push_back(e);
      pend = 0;
      w = rom[{song, 5'(idx)}];
      if (w[10]) begin
        ended = 1;
      end else begin
        beats = (w[8:5] == 4'd0) ? 1 : int'(w[8:5]);
        len = beats * u;
        k = w[4:0];
        for (int c = 0; c < len; c++) begin
          e = '{key: k, on: ((c < len - gap) && !w[9]), busy: 1'b1, idx: 5'(idx), song: song, done: 1'b0};
          q.push_back(e);
        end
        if (idx == 31) ended = 1;
        else idx++;
      end
      if (ended) begin
        iters++;
        if (lp && iters < 4) begin
          idx = 0;
          pend = 1;
        end else begin
          e = '{key: k, on: 1'b0, busy: 1'b0, idx: 5'(idx), song: song, done: 1'b1};
          q.push_back(e);
          break;
        end
      end
    end
  endtask

  logic p_start = 1'b0, p_stop = 1'b0, p_pause = 1'b0, p_loop = 1'b0;
  logic [1:0]  p_sel  = 2'd0;
  logic [25:0] p_unit = 26'd0;

  always @(posedge clk) begin
    p_start <= rst ? 1'b0 : i_start;
    p_stop  <= rst ? 1'b0 : i_stop;
    p_pause <= rst ? 1'b0 : i_pause;
    p_loop  <= i_loop;
    p_sel   <= i_song_sel;
    p_unit  <= i_unit_cycles;
  end

  // Advance the model one clock and compare every output.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      cur = '0;
    end else if (p_stop) begin
      q.delete();
      cur.busy = 1'b0;
      cur.on   = 1'b0;
      cur.done = 1'b0;
    end else if (p_pause) begin
      cur.done = 1'b0;
    end else begin
      if (p_start && !cur.busy) build(p_sel, cur.key, p_unit, p_loop);
      if (q.size() > 0) cur = q.pop_front();
      else cur.done = 1'b0;
    end
    chk("m_key",    32'(o_key),      32'(cur.key));
    chk("m_key_on", 32'(o_key_on),   32'(cur.on & ~i_pause));
    chk("m_busy",   32'(o_busy),     32'(cur.busy));
    chk("m_idx",    32'(o_note_idx), 32'(cur.idx));
    chk("m_addr",   32'(o_rom_addr), 32'({cur.song, cur.idx}));
    chk("m_done",   32'(o_done),     32'(cur.done));
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_song(input logic [1:0] sel, input logic [25:0] unit, input logic lp);
    i_song_sel = sel; i_unit_cycles = unit; i_loop = lp; i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, output int cycles, output int on_cnt, output int busy_low);
    cycles = 0; on_cnt = 0; busy_low = 0;
    while (o_done !== 1'b1 && cycles < budget) begin
      if (o_key_on === 1'b1) on_cnt++;
      if (o_busy !== 1'b1) busy_low++;
      tick();
      cycles++;
    end
    chk("done_seen", 32'(o_done), 32'd1);
  endtask

  int cyc, onc, bl, c2, c3, dn;

  initial begin
    repeat (2) tick();
    chk("rst_key",    32'(o_key),      32'd0);
    chk("rst_key_on", 32'(o_key_on),   32'd0);
    chk("rst_busy",   32'(o_busy),     32'd0);
    chk("rst_idx",    32'(o_note_idx), 32'd0);
    chk("rst_addr",   32'(o_rom_addr), 32'd0);
    chk("rst_done",   32'(o_done),     32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // 1: single two-beat note then end marker
    start_song(2'd0, 26'd8, 1'b0);
    run_until_done(200, cyc, onc, bl);
    chk("t1_cycles", 32'(cyc), 32'd20);
    chk("t1_on",     32'(onc), 32'd14);
    chk("t1_key",    32'(o_key), 32'd3);
    chk("t1_busy",   32'(o_busy), 32'd0);
    repeat (3) tick();

    // 2: rest in the middle of a three-note song
    start_song(2'd1, 26'd8, 1'b0);
    run_until_done(300, cyc, onc, bl);
    chk("t2_cycles", 32'(cyc), 32'd48);
    chk("t2_on",     32'(onc), 32'd28);
    chk("t2_idx",    32'(o_note_idx), 32'd3);
    repeat (3) tick();

    // 3: looping song, three passes, busy never drops
    start_song(2'd2, 26'd8, 1'b1);
    run_until_done(200, cyc, onc, bl);
    chk("t3_idx1", 32'(o_note_idx), 32'd0);
    tick();
    run_until_done(200, c2, onc, dn);
    bl += dn;
    chk("t3_idx2", 32'(o_note_idx), 32'd0);
    tick();
    run_until_done(200, c3, onc, dn);
    bl += dn;
    chk("t3_idx3",  32'(o_note_idx), 32'd0);
    chk("t3_c1",    32'(cyc), 32'd22);
    chk("t3_c2",    32'(c2),  32'd21);
    chk("t3_c3",    32'(c3),  32'd21);
    chk("t3_busy",  32'(bl),  32'd0);
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0; i_loop = 1'b0;
    repeat (3) tick();

    // 4: pause five cycles mid-note stretches the song by five
    start_song(2'd0, 26'd8, 1'b0);
    repeat (6) tick();
    chk("t4_on_before", 32'(o_key_on), 32'd1);
    i_pause = 1'b1;
    #1;
    chk("t4_on_paused", 32'(o_key_on), 32'd0);
    repeat (5) tick();
    i_pause = 1'b0;
    #1;
    chk("t4_on_resumed", 32'(o_key_on), 32'd1);
    run_until_done(200, cyc, onc, bl);
    chk("t4_cycles", 32'(cyc + 11), 32'd25);
    repeat (3) tick();

    // 5: stop and start together mid-song
    start_song(2'd1, 26'd8, 1'b0);
    repeat (15) tick();
    i_stop = 1'b1; i_start = 1'b1;
    tick();
    i_stop = 1'b0; i_start = 1'b0;
    chk("t5_busy",   32'(o_busy),   32'd0);
    chk("t5_key_on", 32'(o_key_on), 32'd0);
    dn = 0; bl = 0;
    for (int i = 0; i < 10; i++) begin
      if (o_done === 1'b1) dn++;
      if (o_busy !== 1'b0) bl++;
      tick();
    end
    chk("t5_no_done", 32'(dn), 32'd0);
    chk("t5_idle",    32'(bl), 32'd0);

    // 6: full 32-entry table, zero tempo treated as one cycle per beat
    start_song(2'd3, 26'd0, 1'b0);
    run_until_done(400, cyc, onc, bl);
    chk("t6_cycles", 32'(cyc), 32'd96);
    chk("t6_on",     32'(onc), 32'd32);
    chk("t6_idx",    32'(o_note_idx), 32'd31);
    repeat (3) tick();

    // 6b: asynchronous reset in the middle of a note
    start_song(2'd3, 26'd8, 1'b0);
    repeat (12) tick();
    chk("t6b_on_pre",  32'(o_key_on), 32'd1);
    chk("t6b_key_pre", 32'(o_key),    32'd2);
    rst = 1'b1;
    #1;
    chk("t6b_key",    32'(o_key),      32'd0);
    chk("t6b_key_on", 32'(o_key_on),   32'd0);
    chk("t6b_busy",   32'(o_busy),     32'd0);
    chk("t6b_idx",    32'(o_note_idx), 32'd0);
    chk("t6b_addr",   32'(o_rom_addr), 32'd0);
    chk("t6b_done",   32'(o_done),     32'd0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
